// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_arbiter_pkg : shared types and widths for the ALU arbiter slice
// Rev 1.0
// ----------------------------------------------------------------------------
package alu_arbiter_pkg;

  localparam int c_OPND_W   = 4;
  localparam int c_RES_W    = 5;
  localparam int c_OP_W     = 2;
  localparam int c_MAX_NREQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_INV = 2'd2,
    OP_ROR = 2'd3
  } opcode_e;

  function automatic logic [2:0] onehot_to_idx(input logic [c_MAX_NREQ-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < c_MAX_NREQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_arbiter_if : requester and response handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int NREQ = 2
);
  import alu_arbiter_pkg::*;

  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [c_OP_W*NREQ-1:0]   req_opcode;
  logic [c_OPND_W*NREQ-1:0] req_a;
  logic [c_OPND_W*NREQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [c_RES_W-1:0]       rsp_data;

  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : one-hot round-robin grant, search starts after last winner
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_last_grant,
  output logic [NREQ-1:0]         o_grant
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(i_last_grant) + k) % NREQ;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_arbiter : round-robin front end sharing one registered ALU
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  alu_arbiter_if.slave        bus,
  output logic [c_OP_W-1:0]   alu_opcode,
  output logic [c_OPND_W-1:0] alu_a,
  output logic [c_OPND_W-1:0] alu_b,
  input  logic [c_RES_W-1:0]  alu_c,
  output logic                busy
);

  localparam int ID_W = $clog2(NREQ);

  state_e                r_state;
  state_e                w_next;
  logic [ID_W-1:0]       r_last_grant;
  logic [ID_W-1:0]       r_id;
  logic [ID_W-1:0]       w_win_id;
  opcode_e               r_opcode;
  logic [c_OPND_W-1:0]   r_a;
  logic [c_OPND_W-1:0]   r_b;
  logic [c_RES_W-1:0]    r_data;
  logic [NREQ-1:0]       w_grant;
  logic [c_MAX_NREQ-1:0] w_grant_ext;
  logic                  w_accept;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_grant_ext = c_MAX_NREQ'(w_grant);
  assign w_win_id    = ID_W'(onehot_to_idx(w_grant_ext));
  // The grant is already masked by req_valid, so any grant in IDLE is a handshake.
  assign w_accept    = (r_state == ST_IDLE) && (|w_grant);

  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (reset_n) bus.req_ready = w_grant;
        if (w_accept) w_next = ST_ISSUE;
      end
      ST_ISSUE:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_RESP;
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = ST_IDLE;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= ID_W'(NREQ - 1);
      r_id         <= '0;
      r_opcode     <= OP_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_data       <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last_grant <= w_win_id;
        r_id         <= w_win_id;
        r_opcode     <= opcode_e'(bus.req_opcode[w_win_id*c_OP_W +: c_OP_W]);
        r_a          <= bus.req_a[w_win_id*c_OPND_W +: c_OPND_W];
        r_b          <= bus.req_b[w_win_id*c_OPND_W +: c_OPND_W];
      end
      if (r_state == ST_CAPTURE) r_data <= alu_c;
    end
  end

  assign alu_opcode   = r_opcode;
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign bus.rsp_id   = r_id;
  assign bus.rsp_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_arbiter : directed vectors with a response scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NREQ = 2;

  typedef struct {
    logic [0:0] id;
    logic [4:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_c = '0;
  logic       busy;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clock = ~clock;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .busy       (busy)
  );

  // Shared ALU with a registered result, operands sign-extended to 5 bits
  function automatic logic [4:0] alu_fn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sa;
    logic [4:0] sb5;
    sa  = {a[3], a};
    sb5 = {b[3], b};
    case (op)
      2'd0:    return sa + sb5;
      2'd1:    return sa - sb5;
      2'd2:    return ~sa;
      default: return {4'b0, |b};
    endcase
  endfunction

  always @(posedge clock) alu_c <= alu_fn(alu_opcode, alu_a, alu_b);

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got id %0d data 0x%0h, want no response", bus.rsp_id, bus.rsp_data);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", int'(bus.rsp_id), int'(mon_e.id));
        check("rsp_data", int'(bus.rsp_data), int'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.req_opcode[id*2 +: 2] = op;
    bus.req_a[id*4 +: 4]      = a;
    bus.req_b[id*4 +: 4]      = b;
    bus.req_valid[id]         = 1'b1;
  endtask

  task automatic wait_grant(input string name, input logic [1:0] exp_ready);
    int n;
    n = 0;
    @(negedge clock);
    while (bus.req_ready == 2'b00 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check(name, int'(bus.req_ready), int'(exp_ready));
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.rsp_valid && n < 20);
  endtask

  task automatic run_op(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp_data, input string name);
    int n;
    set_req(id, op, a, b);
    wait_grant({name, "_grant"}, 2'(1 << id));
    sb.push_back('{id: 1'(id), data: exp_data});
    tick();
    bus.req_valid[id] = 1'b0;
    wait_rsp(n);
    check({name, "_latency"}, n, 3);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int cyc;
    int got;
    int ids[4];
    int at[4];

    bus.req_valid  = 2'b11;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b1;
    reset_n        = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_req_ready", int'(bus.req_ready), 0);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rsp_data", int'(bus.rsp_data), 0);
    check("rst_rsp_id", int'(bus.rsp_id), 0);
    check("rst_alu_opcode", int'(alu_opcode), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_b", int'(alu_b), 0);

    // Both requesters valid straight out of reset: expect 0,1,0,1 at 4-cycle spacing
    bus.req_valid = 2'b00;
    set_req(0, OP_ADD, 4'd1, 4'd2);
    set_req(1, OP_SUB, 4'd1, 4'd2);
    sb.push_back('{id: 1'b0, data: 5'h03});
    sb.push_back('{id: 1'b1, data: 5'h1F});
    sb.push_back('{id: 1'b0, data: 5'h03});
    sb.push_back('{id: 1'b1, data: 5'h1F});
    tick();
    reset_n = 1'b1;
    cyc = 0;
    got = 0;
    while (got < 4 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (bus.req_ready != 2'b00) begin
        ids[got] = bus.req_ready[1] ? 1 : 0;
        at[got]  = cyc;
        got++;
        if (got == 4) begin
          tick();
          bus.req_valid = 2'b00;
        end
      end
    end
    check("rr_grant_count", got, 4);
    for (int k = 0; k < got; k++) check("rr_grant_order", ids[k], k % 2);
    for (int k = 1; k < got; k++) check("rr_grant_spacing", at[k] - at[k-1], 4);
    wait_rsp(n);
    tick();

    run_op(0, OP_ADD, 4'd3, 4'd4, 5'h07, "add_3_4");
    run_op(1, OP_SUB, 4'd2, 4'd5, 5'h1D, "sub_2_5");
    run_op(0, OP_ROR, 4'd5, 4'h0, 5'h00, "ror_b0");
    run_op(0, OP_ROR, 4'd5, 4'h8, 5'h01, "ror_b8");
    run_op(1, OP_INV, 4'd3, 4'd0, 5'h1C, "inv_3");
    run_op(0, OP_ADD, 4'd7, 4'd1, 5'h08, "add_7_1");
    run_op(1, OP_ADD, 4'h8, 4'h8, 5'h10, "add_m8_m8");

    // Stall the response for 5 cycles while requester 1 waits
    bus.rsp_ready = 1'b0;
    set_req(0, OP_ADD, 4'd3, 4'd4);
    set_req(1, OP_SUB, 4'd2, 4'd5);
    wait_grant("stall_grant0", 2'b01);
    sb.push_back('{id: 1'b0, data: 5'h07});
    tick();
    bus.req_valid[0] = 1'b0;
    wait_rsp(n);
    check("stall_latency", n, 3);
    for (int k = 0; k < 5; k++) begin
      check("stall_rsp_valid", int'(bus.rsp_valid), 1);
      check("stall_rsp_data", int'(bus.rsp_data), 32'h07);
      check("stall_rsp_id", int'(bus.rsp_id), 0);
      check("stall_req_ready", int'(bus.req_ready), 0);
      if (k < 4) @(negedge clock);
    end
    tick();
    bus.rsp_ready = 1'b1;
    wait_grant("stall_grant1", 2'b10);
    sb.push_back('{id: 1'b1, data: 5'h1D});
    tick();
    bus.req_valid[1] = 1'b0;
    wait_rsp(n);
    tick();

    // Abort in CAPTURE: no response, then requester 0 regains priority
    set_req(0, OP_ADD, 4'd3, 4'd4);
    wait_grant("abort_grant", 2'b01);
    tick();
    bus.req_valid[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort_in_capture", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_rsp_valid", int'(bus.rsp_valid), 0);
    check("abort_rsp_data", int'(bus.rsp_data), 0);
    check("abort_alu_a", int'(alu_a), 0);
    set_req(0, OP_INV, 4'hA, 4'd0);
    set_req(1, OP_ADD, 4'd1, 4'd1);
    #1;
    check("abort_req_ready", int'(bus.req_ready), 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    wait_grant("post_reset_grant", 2'b01);
    sb.push_back('{id: 1'b0, data: 5'h05});
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(n);
    check("post_reset_latency", n, 3);
    tick();

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
